// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - asynchronous convert request; its rising edge starts a conversion
//   bcd_in      - packed BCD digits, [3:0] = ones
//   bin_out     - binary result, held until the next done
//   err         - per-digit invalid flag (bit0 = ones), held with bin_out
//   busy        - high whenever the FSM is not IDLE
//   done        - one-cycle pulse when bin_out/err have been updated
module bcd_to_bin_seq #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic [DIGITS-1:0]     err,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        sync_q;
  logic              start_edge_c;
  logic [BCD_W-1:0]  bcd_q;
  logic [BIN_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DIGITS-1:0] err_c;
  logic [BCD_W-1:0]  bcd_sh_c, bcd_nx_c;
  logic [BIN_W-1:0]  acc_nx_c;

  // sync_q[1] is the synchronized start; sync_q[2] is its previous value
  assign start_edge_c = sync_q[1] & ~sync_q[2];

  // Synchronizer and edge-detect flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], start};
  end

  // Invalid-digit detection on the latched operand
  always_comb begin
    err_c = '0;
    for (int i = 0; i < int'(DIGITS); i++)
      err_c[i] = (bcd_q[4*i +: 4] > 4'd9);
  end

  // One reverse double-dabble step: shift right, then correct nibbles >= 8
  always_comb begin
    {bcd_sh_c, acc_nx_c} = {bcd_q, acc_q} >> 1;
    bcd_nx_c = bcd_sh_c;
    for (int i = 0; i < int'(DIGITS); i++)
      if (bcd_sh_c[4*i +: 4] >= 4'd8)
        bcd_nx_c[4*i +: 4] = bcd_sh_c[4*i +: 4] - 4'd3;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; edge requests outside IDLE are simply ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_edge_c) state_d = CHECK;
      CHECK:   state_d = (|err_c) ? DONE : SHIFT;
      SHIFT:   if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bin_out <= '0;
      err     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      done <= (state_d == DONE);
      case (state_q)
        IDLE: if (start_edge_c) bcd_q <= bcd_in;
        CHECK: begin
          err   <= err_c;
          acc_q <= '0;
          cnt_q <= '0;
          if (|err_c) bin_out <= '0;
        end
        SHIFT: begin
          bcd_q <= bcd_nx_c;
          acc_q <= acc_nx_c;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) bin_out <= acc_nx_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd_in;
  logic [9:0]  bin_out;
  logic [2:0]  err;
  logic        busy;
  logic        done;

  bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .bin_out(bin_out), .err(err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    int err;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   ncmp = 0;
  int   nbad = 0;
  int   ndone = 0;
  int   npush = 0;
  bit   chk_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_busy) begin
        check("busy_after_done", int'(busy), 0);
        chk_busy = 1'b0;
      end
      if (done) begin
        ndone++;
        chk_busy = 1'b1;
        if (sb.size() == 0) begin
          ncmp++;
          nbad++;
          $display("FAIL unexpected_done: bin_out=%0d err=%0d at cycle %0d", bin_out, err, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("bin_out", int'(bin_out), e.bin);
          check("err", int'(err), e.err);
          check("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Drive a request at a negedge so it is first sampled at edge N = cyc+1
  task automatic issue(input logic [11:0] v, input int hold,
                       input int eb, input int ee, input bit is_err);
    exp_t e;
    @(negedge clk);
    bcd_in = v;
    start  = 1'b1;
    e.bin = eb;
    e.err = ee;
    e.cyc = cyc + 1 + (is_err ? 3 : 13);
    sb.push_back(e);
    npush++;
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle_wait();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      if (!busy && !done) break;
      @(negedge clk);
    end
    check("idle_wait_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    repeat (3) @(negedge clk);
    check("rst_bin_out", int'(bin_out), 0);
    check("rst_err", int'(err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(12'h999, 1, 999, 0, 1'b0); idle_wait();
    issue(12'h000, 1, 0, 0, 1'b0);   idle_wait();
    issue(12'h255, 2, 255, 0, 1'b0); idle_wait();
    issue(12'h1A5, 1, 0, 3'b010, 1'b1); idle_wait();
    issue(12'hFFF, 1, 0, 3'b111, 1'b1); idle_wait();
    issue(12'h087, 1, 87, 0, 1'b0);  idle_wait();

    // Held start: exactly one conversion, then release and re-press
    issue(12'h042, 40, 42, 0, 1'b0); idle_wait();
    issue(12'h100, 2, 100, 0, 1'b0); idle_wait();

    // Operand change and re-pulse mid-conversion are ignored
    issue(12'h321, 1, 321, 0, 1'b0);
    repeat (4) @(negedge clk);
    bcd_in = 12'h777;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    idle_wait();

    // Reset mid-conversion: no done, outputs cleared at once
    @(negedge clk);
    bcd_in = 12'h500;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_bin_out", int'(bin_out), 0);
    check("abort_err", int'(err), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    // Start already held high across reset release counts as a new edge
    bcd_in = 12'h064;
    start  = 1'b1;
    repeat (3) @(negedge clk);
    begin
      exp_t e;
      rst_n = 1'b1;
      e.bin = 64;
      e.err = 0;
      e.cyc = cyc + 1 + 13;
      sb.push_back(e);
      npush++;
    end
    repeat (5) @(negedge clk);
    start = 1'b0;
    idle_wait();

    repeat (5) @(negedge clk);
    check("queue_drained", sb.size(), 0);
    check("done_count", ndone, npush);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

Interface
REQ-001 The block SHALL have exactly the parameters in REQ-002..REQ-003.
REQ-002 Parameter DIGITS, default 3: number of BCD digits converted.
REQ-003 Parameter BIN_W, default 10: binary result width; SHALL equal ceil(log2(10^DIGITS)).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  convert request; level from pushbutton, asynchronous to clk.
REQ-007 bcd_in  input  4*DIGITS  packed BCD; [3:0] ones, [7:4] tens, [11:8] hundreds.
REQ-008 bin_out  output  BIN_W  binary result; held until next done.
REQ-009 err  output  DIGITS  per-digit invalid flag (bit0 ones); held with bin_out.
REQ-010 busy  output  1  high whenever the FSM is not IDLE.
REQ-011 done  output  1  one-cycle pulse marking bin_out/err update.

Function
REQ-012 start SHALL pass a 2-flop synchronizer; a third flop provides rising-edge detect. Only a 0->1 transition of the synchronized start SHALL request a conversion.
REQ-013 FSM states SHALL be IDLE, CHECK, SHIFT, DONE.
REQ-014 Timing reference: start first sampled high at edge N. The edge request is seen at edge N+2.
REQ-015 IDLE: on the edge request at N+2, bcd_in SHALL be latched internally, and the FSM SHALL go to CHECK.
REQ-016 CHECK: at edge N+3, err[i] SHALL be set for every latched nibble > 9.
REQ-017 CHECK, any err set: the FSM SHALL go to DONE, bin_out SHALL be 0, and done SHALL be high in the cycle after N+3.
REQ-018 CHECK, no err: the FSM SHALL go to SHIFT with shift counter = 0 and binary accumulator = 0.
REQ-019 SHIFT, each edge: shift {bcd, acc} right 1 bit. Then, in every BCD nibble whose post-shift value is >= 8, subtract 3.
REQ-020 SHIFT SHALL last exactly BIN_W edges (N+4..N+3+BIN_W). The final edge SHALL load bin_out with the accumulator and enter DONE.
REQ-021 Valid-input latency: done SHALL be high in the cycle after edge N+3+BIN_W (N+13 by default).
REQ-022 DONE SHALL last one cycle, then return to IDLE; done SHALL be high only in that cycle.
REQ-023 Edge requests arriving while busy SHALL be dropped, not queued.
REQ-024 Changes on bcd_in after latch SHALL NOT affect the result in progress.
REQ-025 start held high SHALL yield exactly one conversion; a new conversion requires release and re-press.
REQ-026 The result SHALL equal 100*H + 10*T + O; the maximum 999 SHALL fit BIN_W = 10 without overflow.

Reset
REQ-027 While rst_n = 0: bin_out = 0, err = 0, busy = 0, done = 0, FSM = IDLE, all synchronizer/edge flops = 0, accumulator/counter = 0.
REQ-028 Reset asserted mid-conversion SHALL abort it immediately, with no done pulse.
REQ-029 After rst_n release, a start already held high SHALL be treated as a new rising edge (one conversion).

Verification
REQ-030 bcd_in = 0x999, start pulse at N -> done in cycle after N+13, bin_out = 999 (0x3E7), err = 000.
REQ-031 bcd_in = 0x000 -> bin_out = 0, err = 000, done after N+13; bcd_in = 0x255 -> bin_out = 255.
REQ-032 bcd_in = 0x1A5 -> done in cycle after N+3, err = 010, bin_out = 0, busy low from the following cycle.
REQ-033 bcd_in = 0x042, start held 40 cycles -> exactly one done, bin_out = 42. Then release and re-press with 0x100 -> bin_out = 100.
REQ-034 Start 0x321; at N+5 change bcd_in to 0x777 and re-pulse start -> single done, bin_out = 321.
REQ-035 Start 0x500; assert rst_n low at N+7 -> all outputs 0 immediately, no done. Release, pulse start with 0x064 -> bin_out = 64.
